// File: rtl/video_timing_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : video_timing_pkg
// Purpose  : Standard raster timing constants (480p, 720p, 1080p) and a
//            helper that sums the four segments of one timing axis.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

  // 640x480 @ 60 Hz
  localparam int c_480p_h_sync   = 96;
  localparam int c_480p_h_back   = 48;
  localparam int c_480p_h_disp   = 640;
  localparam int c_480p_h_front  = 16;
  localparam int c_480p_v_sync   = 2;
  localparam int c_480p_v_back   = 33;
  localparam int c_480p_v_disp   = 480;
  localparam int c_480p_v_front  = 10;

  // 1280x720 @ 60 Hz
  localparam int c_720p_h_sync   = 40;
  localparam int c_720p_h_back   = 220;
  localparam int c_720p_h_disp   = 1280;
  localparam int c_720p_h_front  = 110;
  localparam int c_720p_v_sync   = 5;
  localparam int c_720p_v_back   = 20;
  localparam int c_720p_v_disp   = 720;
  localparam int c_720p_v_front  = 5;

  // 1920x1080 @ 60 Hz
  localparam int c_1080p_h_sync  = 44;
  localparam int c_1080p_h_back  = 148;
  localparam int c_1080p_h_disp  = 1920;
  localparam int c_1080p_h_front = 88;
  localparam int c_1080p_v_sync  = 5;
  localparam int c_1080p_v_back  = 36;
  localparam int c_1080p_v_disp  = 1080;
  localparam int c_1080p_v_front = 4;

  // Total length of one axis (pixels per line or lines per frame).
  function automatic int total(input int sync, input int back,
                               input int disp, input int front);
    return sync + back + disp + front;
  endfunction

endpackage : video_timing_pkg
`default_nettype wire

// File: rtl/video_hv_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : video_hv_counter
// Purpose  : Horizontal/vertical raster position counters. h runs
//            0..H_TOTAL-1; v advances on each h wrap and runs 0..V_TOTAL-1.
// Ports    : clk, rst        - clock, async active-high reset
//            i_clear         - hold both counters at 0 (priority over i_en)
//            i_en            - advance the raster position
//            o_h, o_v        - current position
//            o_frame_end     - position is the last pixel of the frame
// Revision : 1.0 - initial release
// ============================================================================
module video_hv_counter #(
  parameter int H_TOTAL = 1650,
  parameter int V_TOTAL = 750,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_h,
  output logic [CNT_W-1:0] o_v,
  output logic             o_frame_end
);

  localparam logic [CNT_W-1:0] c_h_last = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] c_v_last = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             w_h_wrap;
  logic             w_v_wrap;

  assign w_h_wrap = (r_h == c_h_last);
  assign w_v_wrap = (r_v == c_v_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_clear) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_en) begin
      if (w_h_wrap) begin
        r_h <= '0;
        r_v <= w_v_wrap ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign o_h         = r_h;
  assign o_v         = r_v;
  assign o_frame_end = w_h_wrap && w_v_wrap;

endmodule : video_hv_counter
`default_nettype wire

// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Parametrised raster timing generator. Registered hs/vs/de and
//            gated RGB888, a pixel request with 0-based coordinates issued
//            DATA_LEAD cycles ahead of each active pixel, a frame_start pulse
//            and a run/stop control that only stops on a frame boundary.
// Ports    : pixel_clk, sys_rst          - clock, async active-high reset
//            run                         - 1 = generate, 0 = stop at frame end
//            pixel_data                  - RGB888 from the pixel source
//            video_hs/vs/de/rgb          - timed video to the encoder
//            data_req, pixel_xpos/ypos   - pixel request and its coordinates
//            frame_start                 - pulse aligned with raster (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_SYNC    = 40,
  parameter int   H_BACK    = 220,
  parameter int   H_DISP    = 1280,
  parameter int   H_FRONT   = 110,
  parameter int   V_SYNC    = 5,
  parameter int   V_BACK    = 20,
  parameter int   V_DISP    = 720,
  parameter int   V_FRONT   = 5,
  parameter logic HS_POL    = 1'b1,
  parameter logic VS_POL    = 1'b1,
  parameter int   DATA_LEAD = 1,
  parameter int   CNT_W     = 12
) (
  input  logic             pixel_clk,
  input  logic             sys_rst,
  input  logic             run,
  input  logic [23:0]      pixel_data,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_de,
  output logic [23:0]      video_rgb,
  output logic             data_req,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic             frame_start
);

  localparam int c_h_total   = total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int c_v_total   = total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int c_ha0       = H_SYNC + H_BACK;
  localparam int c_va0       = V_SYNC + V_BACK;
  localparam int c_de_end    = c_ha0 + H_DISP;
  localparam int c_v_end     = c_va0 + V_DISP;
  // The request window is the active window shifted DATA_LEAD pixels earlier.
  localparam int c_req_start = c_ha0 - DATA_LEAD;
  localparam int c_req_end   = c_de_end - DATA_LEAD;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_frame_end;
  logic             w_idle;
  logic             w_v_act;
  logic             w_de;
  logic             w_req;
  logic [CNT_W-1:0] w_xpos;
  logic [CNT_W-1:0] w_ypos;

  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic [23:0]      r_rgb;
  logic             r_req;
  logic [CNT_W-1:0] r_xpos;
  logic [CNT_W-1:0] r_ypos;
  logic             r_frame_start;

  assign w_idle = (r_state == c_st_idle);

  video_hv_counter #(
    .H_TOTAL (c_h_total),
    .V_TOTAL (c_v_total),
    .CNT_W   (CNT_W)
  ) u_hv_counter (
    .clk         (pixel_clk),
    .rst         (sys_rst),
    .i_clear     (w_idle),
    .i_en        (!w_idle),
    .o_h         (w_h),
    .o_v         (w_v),
    .o_frame_end (w_frame_end)
  );

  // DRAIN keeps the frame running; only the last pixel of the frame may
  // drop back to IDLE, so stopping never truncates a frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (run) w_state_nxt = c_st_run;
      c_st_run:   if (!run) w_state_nxt = c_st_drain;
      c_st_drain: begin
        if (run)              w_state_nxt = c_st_run;
        else if (w_frame_end) w_state_nxt = c_st_idle;
      end
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  assign w_v_act = (w_v >= CNT_W'(c_va0)) && (w_v < CNT_W'(c_v_end));
  assign w_de    = w_v_act && (w_h >= CNT_W'(c_ha0)) && (w_h < CNT_W'(c_de_end));
  assign w_req   = w_v_act && (w_h >= CNT_W'(c_req_start)) && (w_h < CNT_W'(c_req_end));
  // Subtractions only take effect inside the request window, so never underflow.
  assign w_xpos  = w_req ? (w_h - CNT_W'(c_req_start)) : '0;
  assign w_ypos  = w_req ? (w_v - CNT_W'(c_va0)) : '0;

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= c_st_idle;
      r_hs          <= ~HS_POL;
      r_vs          <= ~VS_POL;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_req         <= 1'b0;
      r_xpos        <= '0;
      r_ypos        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle) begin
        r_hs          <= ~HS_POL;
        r_vs          <= ~VS_POL;
        r_de          <= 1'b0;
        r_rgb         <= '0;
        r_req         <= 1'b0;
        r_xpos        <= '0;
        r_ypos        <= '0;
        r_frame_start <= 1'b0;
      end else begin
        r_hs          <= (w_h < CNT_W'(H_SYNC)) ? HS_POL : ~HS_POL;
        r_vs          <= (w_v < CNT_W'(V_SYNC)) ? VS_POL : ~VS_POL;
        r_de          <= w_de;
        r_rgb         <= w_de ? pixel_data : '0;
        r_req         <= w_req;
        r_xpos        <= w_xpos;
        r_ypos        <= w_ypos;
        r_frame_start <= (w_h == '0) && (w_v == '0);
      end
    end
  end

  assign video_hs    = r_hs;
  assign video_vs    = r_vs;
  assign video_de    = r_de;
  assign video_rgb   = r_rgb;
  assign data_req    = r_req;
  assign pixel_xpos  = r_xpos;
  assign pixel_ypos  = r_ypos;
  assign frame_start = r_frame_start;

endmodule : video_timing_gen
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Self-checking bench for video_timing_gen on a small raster
//            (H 2/3/8/2, V 1/2/4/1, active-low syncs, DATA_LEAD=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  localparam int H_SYNC = 2, H_BACK = 3, H_DISP = 8, H_FRONT = 2;
  localparam int V_SYNC = 1, V_BACK = 2, V_DISP = 4, V_FRONT = 1;
  localparam int LEAD   = 2;
  localparam int CW     = 12;
  localparam int HT     = H_SYNC + H_BACK + H_DISP + H_FRONT;  // 15
  localparam int VT     = V_SYNC + V_BACK + V_DISP + V_FRONT;  // 8
  localparam int FRAME  = HT * VT;                             // 120
  localparam int HA0    = H_SYNC + H_BACK;                     // 5
  localparam int VA0    = V_SYNC + V_BACK;                     // 3

  typedef logic [52:0] vec_t;  // {hs,vs,de,req,fs,xpos,ypos,rgb}

  logic          pixel_clk = 1'b0;
  logic          sys_rst   = 1'b0;
  logic          run       = 1'b0;
  logic [23:0]   pixel_data = '0;
  logic          video_hs, video_vs, video_de, data_req, frame_start;
  logic [23:0]   video_rgb;
  logic [CW-1:0] pixel_xpos, pixel_ypos;

  int n_vec = 0;
  int n_err = 0;

  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_DISP(H_DISP), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_DISP(V_DISP), .V_FRONT(V_FRONT),
    .HS_POL(1'b0), .VS_POL(1'b0), .DATA_LEAD(LEAD), .CNT_W(CW)
  ) dut (
    .pixel_clk   (pixel_clk),
    .sys_rst     (sys_rst),
    .run         (run),
    .pixel_data  (pixel_data),
    .video_hs    (video_hs),
    .video_vs    (video_vs),
    .video_de    (video_de),
    .video_rgb   (video_rgb),
    .data_req    (data_req),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .frame_start (frame_start)
  );

  // Pixel source with one cycle of latency: returns {ypos,xpos} for a request,
  // random junk otherwise.
  always @(posedge pixel_clk)
    pixel_data <= data_req ? {pixel_ypos, pixel_xpos} : 24'($urandom);

  vec_t dut_vec;
  assign dut_vec = {video_hs, video_vs, video_de, data_req, frame_start,
                    pixel_xpos, pixel_ypos, video_rgb};

  // Expected outputs for a raster position (frame-linear index pos).
  function automatic vec_t model_out(input bit on, input int pos);
    int h, v;
    bit hs, vs, de, req, fs, vwin;
    logic [CW-1:0] x, y;
    logic [23:0]   rgb;
    if (!on) return {1'b1, 1'b1, 3'b000, 12'd0, 12'd0, 24'd0};
    h    = pos % HT;
    v    = pos / HT;
    hs   = !(h < H_SYNC);
    vs   = !(v < V_SYNC);
    vwin = (v >= VA0) && (v < VA0 + V_DISP);
    de   = vwin && (h >= HA0) && (h < HA0 + H_DISP);
    req  = vwin && (h >= HA0 - LEAD) && (h < HA0 + H_DISP - LEAD);
    x    = req ? CW'(h - (HA0 - LEAD)) : '0;
    y    = req ? CW'(v - VA0) : '0;
    fs   = (pos == 0);
    rgb  = de ? {CW'(v - VA0), CW'(h - HA0)} : 24'd0;
    return {hs, vs, de, req, fs, x, y, rgb};
  endfunction

  // Reference: m_on = generating frames, m_stop = run was low at the last
  // edge (a stop is pending), m_pos = position in the frame.
  bit   m_on, m_stop;
  int   m_pos;
  vec_t exp_vec;

  always @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_on    <= 1'b0;
      m_stop  <= 1'b0;
      m_pos   <= 0;
      exp_vec <= model_out(1'b0, 0);
    end else begin
      exp_vec <= model_out(m_on, m_pos);
      if (!m_on) begin
        m_pos  <= 0;
        m_stop <= 1'b0;
        if (run) m_on <= 1'b1;
      end else begin
        m_pos  <= (m_pos + 1) % FRAME;
        m_stop <= !run;
        if (m_stop && !run && m_pos == FRAME - 1) m_on <= 1'b0;
      end
    end
  end

  task automatic test_reset();
    run = 1'b0;
    #1 sys_rst = 1'b1;
    #2;
    n_vec++;
    if (dut_vec !== model_out(1'b0, 0)) begin
      n_err++;
      $display("FAIL reset_idle act=%h exp=%h", dut_vec, model_out(1'b0, 0));
    end
    repeat (3) @(negedge pixel_clk);
    sys_rst = 1'b0;
    run     = 1'b1;
    @(posedge pixel_clk); #1;
    n_vec++;
    if (frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL fs_edge1 act=%b exp=0", frame_start);
    end
    @(posedge pixel_clk); #1;
    n_vec++;
    if (frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL fs_edge2 act=%b exp=1", frame_start);
    end
  endtask

  task automatic test_frame_timing();
    int last_fs = -1, hs_low = 0, vs_run = 0;
    bit seen_vs_high = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge pixel_clk);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL timing_cycle k=%0d act=%h exp=%h", k, dut_vec, exp_vec);
      end
      if (!video_hs) hs_low++;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          n_vec++;
          if (k - last_fs != FRAME) begin
            n_err++;
            $display("FAIL fs_period act=%0d exp=%0d", k - last_fs, FRAME);
          end
        end
        last_fs = k;
      end
      if (!video_vs) vs_run++;
      else begin
        if (seen_vs_high && vs_run != 0) begin
          n_vec++;
          if (vs_run != V_SYNC * HT) begin
            n_err++;
            $display("FAIL vs_width act=%0d exp=%0d", vs_run, V_SYNC * HT);
          end
        end
        seen_vs_high = 1'b1;
        vs_run = 0;
      end
    end
    n_vec++;
    if (hs_low != 3 * VT * H_SYNC) begin
      n_err++;
      $display("FAIL hs_low_count act=%0d exp=%0d", hs_low, 3 * VT * H_SYNC);
    end
  endtask

  task automatic test_active_window();
    int de_cnt = 0, first_de = -1, guard = 0;
    int line_de [VT];
    foreach (line_de[i]) line_de[i] = 0;
    while (frame_start !== 1'b1 && guard < 2 * FRAME) begin
      @(negedge pixel_clk);
      guard++;
    end
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge pixel_clk);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL window_cycle k=%0d act=%h exp=%h", k, dut_vec, exp_vec);
      end
      if (video_de === 1'b1) begin
        de_cnt++;
        line_de[k / HT]++;
        if (first_de < 0) first_de = k;
      end
    end
    n_vec++;
    if (de_cnt != H_DISP * V_DISP) begin
      n_err++;
      $display("FAIL de_count act=%0d exp=%0d", de_cnt, H_DISP * V_DISP);
    end
    n_vec++;
    if (first_de != VA0 * HT + HA0) begin
      n_err++;
      $display("FAIL first_de act=%0d exp=%0d", first_de, VA0 * HT + HA0);
    end
    for (int l = 0; l < VT; l++) begin
      n_vec++;
      if (line_de[l] != ((l >= VA0 && l < VA0 + V_DISP) ? H_DISP : 0)) begin
        n_err++;
        $display("FAIL line_de l=%0d act=%0d", l, line_de[l]);
      end
    end
  endtask

  task automatic test_pixel_source();
    logic [23:0] req_q[$];
    logic [23:0] rgb_q[$];
    logic [23:0] want;
    int guard = 0;
    while (frame_start !== 1'b1 && guard < 2 * FRAME) begin
      @(negedge pixel_clk);
      guard++;
    end
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge pixel_clk);
      if (data_req === 1'b1) req_q.push_back({pixel_ypos, pixel_xpos});
      if (video_de === 1'b1) rgb_q.push_back(video_rgb);
      else begin
        n_vec++;
        if (video_rgb !== 24'd0) begin
          n_err++;
          $display("FAIL rgb_blank k=%0d act=%h exp=0", k, video_rgb);
        end
      end
    end
    n_vec++;
    if (req_q.size() != H_DISP * V_DISP || rgb_q.size() != H_DISP * V_DISP) begin
      n_err++;
      $display("FAIL stream_len req=%0d rgb=%0d exp=%0d", req_q.size(), rgb_q.size(), H_DISP * V_DISP);
    end else begin
      for (int i = 0; i < H_DISP * V_DISP; i++) begin
        want = {CW'(i / H_DISP), CW'(i % H_DISP)};
        n_vec++;
        if (req_q[i] !== want || rgb_q[i] !== want) begin
          n_err++;
          $display("FAIL pixel_order i=%0d req=%h rgb=%h exp=%h", i, req_q[i], rgb_q[i], want);
        end
      end
    end
  endtask

  task automatic test_stop();
    int guard = 0, fs_seen = 0, fs_at = -1;
    while (!(m_on && m_pos == 4 * HT + 7) && guard < 2 * FRAME) begin
      @(negedge pixel_clk);
      guard++;
    end
    run = 1'b0;
    guard = 0;
    while (m_on && guard < 2 * FRAME) begin
      @(negedge pixel_clk);
      guard++;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL drain_cycle act=%h exp=%h", dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (guard != FRAME - (4 * HT + 7)) begin
      n_err++;
      $display("FAIL drain_len act=%0d exp=%0d", guard, FRAME - (4 * HT + 7));
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge pixel_clk);
      if (frame_start === 1'b1) fs_seen++;
      n_vec++;
      if (dut_vec !== model_out(1'b0, 0)) begin
        n_err++;
        $display("FAIL idle_outputs k=%0d act=%h exp=%h", k, dut_vec, model_out(1'b0, 0));
      end
    end
    n_vec++;
    if (fs_seen != 0) begin
      n_err++;
      $display("FAIL idle_no_fs act=%0d exp=0", fs_seen);
    end
    run = 1'b1;
    @(posedge pixel_clk); #1;
    n_vec++;
    if (frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL restart_edge1 act=%b exp=0", frame_start);
    end
    @(posedge pixel_clk); #1;
    n_vec++;
    if (frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL restart_edge2 act=%b exp=1", frame_start);
    end
    @(negedge pixel_clk);
    for (int k = 1; k <= FRAME + 5; k++) begin
      @(negedge pixel_clk);
      if (k == 30) run = 1'b0;
      if (k == 31) run = 1'b1;
      if (frame_start === 1'b1 && fs_at < 0) fs_at = k;
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL toggle_cycle k=%0d act=%h exp=%h", k, dut_vec, exp_vec);
      end
    end
    n_vec++;
    if (fs_at != FRAME) begin
      n_err++;
      $display("FAIL toggle_period act=%0d exp=%0d", fs_at, FRAME);
    end
  endtask

  task automatic test_random_run();
    int hold = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge pixel_clk);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random_cycle k=%0d act=%h exp=%h", k, dut_vec, exp_vec);
      end
      if (hold == 0) begin
        run  = ($urandom_range(0, 2) != 0);
        hold = $urandom_range(1, 180);
      end else begin
        hold--;
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    run = 1'b1;
    while (video_de !== 1'b1 && guard < 4 * FRAME) begin
      @(negedge pixel_clk);
      guard++;
    end
    n_vec++;
    if (video_de !== 1'b1) begin
      n_err++;
      $display("FAIL wait_de_timeout act=%b exp=1", video_de);
    end
    #2 sys_rst = 1'b1;
    #1;
    n_vec++;
    if (dut_vec !== model_out(1'b0, 0)) begin
      n_err++;
      $display("FAIL async_rst act=%h exp=%h", dut_vec, model_out(1'b0, 0));
    end
    @(negedge pixel_clk);
    sys_rst = 1'b0;
    @(posedge pixel_clk); #1;
    n_vec++;
    if (frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL rst_fs_edge1 act=%b exp=0", frame_start);
    end
    @(posedge pixel_clk); #1;
    n_vec++;
    if (frame_start !== 1'b1) begin
      n_err++;
      $display("FAIL rst_fs_edge2 act=%b exp=1", frame_start);
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge pixel_clk);
      n_vec++;
      if (dut_vec !== exp_vec) begin
        n_err++;
        $display("FAIL post_rst_cycle k=%0d act=%h exp=%h", k, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_active_window();
    test_pixel_source();
    test_stop();
    test_random_run();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_video_timing_gen
`default_nettype wire
